dtmf_peak_detector: RTL



---
 rtl/dtmf_peak_detector.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/dtmf_peak_detector.sv
// DTMF peak detector: picks the strongest above-threshold bin in a low and a high band
// per FFT frame and reports the bin pair once it has been identical for STABLE_FRAMES frames.
module dtmf_peak_detector #(
  parameter int MAG_W         = 16,
  parameter int BIN_W         = 6,
  parameter int N_BINS        = 64,
  parameter int LOW_LO        = 19,
  parameter int LOW_HI        = 25,
  parameter int HIGH_LO       = 32,
  parameter int HIGH_HI       = 43,
  parameter int THRESH        = 300,
  parameter int STABLE_FRAMES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_start,
  input  logic             bin_valid,
  input  logic [MAG_W-1:0] bin_mag,
  output logic [BIN_W-1:0] low_bin,
  output logic [BIN_W-1:0] high_bin,
  output logic             tone_valid,
  output logic             tone_new,
  output logic             frame_done,
  output logic             frame_err
);

  localparam int CNT_W = $clog2(STABLE_FRAMES + 1);

  localparam logic [BIN_W-1:0] LAST_IDX  = BIN_W'(N_BINS - 1);
  localparam logic [BIN_W-1:0] LOW_LO_I  = BIN_W'(LOW_LO);
  localparam logic [BIN_W-1:0] LOW_HI_I  = BIN_W'(LOW_HI);
  localparam logic [BIN_W-1:0] HIGH_LO_I = BIN_W'(HIGH_LO);
  localparam logic [BIN_W-1:0] HIGH_HI_I = BIN_W'(HIGH_HI);
  localparam logic [MAG_W-1:0] THRESH_M  = MAG_W'(THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_FRAMES);

  typedef enum logic [1:0] {IDLE, SCAN, DECIDE} state_e;

  state_e state_q, state_d;

  logic [BIN_W-1:0] idx_q, idx_d;
  logic [MAG_W-1:0] max_low_q, max_low_d, max_high_q, max_high_d;
  logic             low_found_q, low_found_d, high_found_q, high_found_d;
  logic [BIN_W-1:0] best_low_q, best_low_d, best_high_q, best_high_d;
  logic [BIN_W-1:0] cand_low_q, cand_low_d, cand_high_q, cand_high_d;
  logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
  logic             decide_q;
  logic [BIN_W-1:0] low_bin_q, low_bin_d, high_bin_q, high_bin_d;
  logic             tone_valid_q, tone_valid_d, tone_new_q, tone_new_d;
  logic             frame_done_q, frame_done_d, frame_err_q, frame_err_d;

  logic             start_beat, accept, last_beat, decide;
  logic [BIN_W-1:0] eval_idx;

  // A frame_start beat restarts the frame from any state; plain beats only count in SCAN.
  assign start_beat = bin_valid & frame_start;
  assign accept     = start_beat | (bin_valid & (state_q == SCAN));
  assign eval_idx   = start_beat ? '0 : idx_q;
  assign last_beat  = accept && (eval_idx == LAST_IDX);
  assign decide     = (state_q == DECIDE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = last_beat ? DECIDE : SCAN;
      SCAN:    if (accept) state_d = last_beat ? DECIDE : SCAN;
      DECIDE:  state_d = accept ? (last_beat ? DECIDE : SCAN) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    frame_done_d = (state_q == DECIDE);
    frame_err_d  = (state_q == SCAN) && start_beat;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    idx_d        = idx_q;
    max_low_d    = max_low_q;
    max_high_d   = max_high_q;
    low_found_d  = low_found_q;
    high_found_d = high_found_q;
    best_low_d   = best_low_q;
    best_high_d  = best_high_q;
    if (accept) begin
      idx_d = eval_idx + 1'b1;
      if (start_beat) begin
        max_low_d    = '0;
        max_high_d   = '0;
        low_found_d  = 1'b0;
        high_found_d = 1'b0;
        best_low_d   = '0;
        best_high_d  = '0;
      end
      // Strict compares keep the lowest index on a tie.
      if (eval_idx >= LOW_LO_I && eval_idx <= LOW_HI_I &&
          bin_mag > THRESH_M && bin_mag > max_low_d) begin
        max_low_d   = bin_mag;
        best_low_d  = eval_idx;
        low_found_d = 1'b1;
      end
      if (eval_idx >= HIGH_LO_I && eval_idx <= HIGH_HI_I &&
          bin_mag > THRESH_M && bin_mag > max_high_d) begin
        max_high_d   = bin_mag;
        best_high_d  = eval_idx;
        high_found_d = 1'b1;
      end
    end
  end

  // Debounce in DECIDE reads the latched maxima, so a concurrent restart cannot disturb it.
  always_comb begin
    stable_cnt_d = stable_cnt_q;
    cand_low_d   = cand_low_q;
    cand_high_d  = cand_high_q;
    low_bin_d    = low_bin_q;
    high_bin_d   = high_bin_q;
    tone_valid_d = tone_valid_q;
    tone_new_d   = 1'b0;
    if (decide) begin
      if (low_found_q && high_found_q) begin
        if (best_low_q == cand_low_q && best_high_q == cand_high_q) begin
          if (stable_cnt_q != CNT_MAX) stable_cnt_d = stable_cnt_q + 1'b1;
        end else begin
          stable_cnt_d = CNT_W'(1);
          cand_low_d   = best_low_q;
          cand_high_d  = best_high_q;
          tone_valid_d = 1'b0;
        end
      end else begin
        stable_cnt_d = '0;
        tone_valid_d = 1'b0;
      end
    end
    if (decide_q && stable_cnt_q == CNT_MAX) begin
      tone_new_d   = !tone_valid_q || low_bin_q != cand_low_q || high_bin_q != cand_high_q;
      tone_valid_d = 1'b1;
      low_bin_d    = cand_low_q;
      high_bin_d   = cand_high_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q        <= '0;
      max_low_q    <= '0;
      max_high_q   <= '0;
      low_found_q  <= 1'b0;
      high_found_q <= 1'b0;
      best_low_q   <= '0;
      best_high_q  <= '0;
      cand_low_q   <= '0;
      cand_high_q  <= '0;
      stable_cnt_q <= '0;
      decide_q     <= 1'b0;
      low_bin_q    <= '0;
      high_bin_q   <= '0;
      tone_valid_q <= 1'b0;
      tone_new_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      max_low_q    <= max_low_d;
      max_high_q   <= max_high_d;
      low_found_q  <= low_found_d;
      high_found_q <= high_found_d;
      best_low_q   <= best_low_d;
      best_high_q  <= best_high_d;
      cand_low_q   <= cand_low_d;
      cand_high_q  <= cand_high_d;
      stable_cnt_q <= stable_cnt_d;
      decide_q     <= decide;
      low_bin_q    <= low_bin_d;
      high_bin_q   <= high_bin_d;
      tone_valid_q <= tone_valid_d;
      tone_new_q   <= tone_new_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign low_bin    = low_bin_q;
  assign high_bin   = high_bin_q;
  assign tone_valid = tone_valid_q;
  assign tone_new   = tone_new_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule
